// File: rtl/tc_parade_timed.sv
// Two-street traffic-light controller with a parade mode that holds street B green.
// Green phases have a minimum and optional maximum length; yellow phases have a fixed length.
module tc_parade_timed #(
    parameter int CNT_W         = 8,
    parameter int MIN_GREEN     = 10,
    parameter int MAX_GREEN     = 0,
    parameter int YELLOW_CYCLES = 5
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       P,
    input  logic       R,
    input  logic       T_A,
    input  logic       T_B,
    output logic [2:0] L_A,
    output logic [2:0] L_B,
    output logic       MODE,
    output logic [1:0] STATE
);

    typedef enum logic [1:0] {
        ST_AG = 2'b00,
        ST_AY = 2'b01,
        ST_BG = 2'b10,
        ST_BY = 2'b11
    } state_t;

    // Last timer value of each phase; the timer counts 0 .. length-1.
    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(YELLOW_CYCLES - 1);
    localparam bit               MAX_EN   = (MAX_GREEN != 0);

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] timer_q, timer_d;

    logic min_done, max_done, yel_done;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        mode_d = mode_q;
        if (P && !R) begin
            mode_d = 1'b1;
        end else if (R && !P) begin
            mode_d = 1'b0;
        end

        min_done = (timer_q >= MIN_LAST);
        max_done = MAX_EN && (timer_q >= MAX_LAST);
        yel_done = (timer_q == Y_LAST);

        state_d = state_q;
        case (state_q)
            ST_AG: if (min_done && (!T_A || mode_q || max_done)) state_d = ST_AY;
            ST_AY: if (yel_done) state_d = ST_BG;
            // Parade mode pins street B green; the maximum is ignored there.
            ST_BG: if (!mode_q && min_done && (!T_B || max_done)) state_d = ST_BY;
            ST_BY: if (yel_done) state_d = ST_AG;
            default: state_d = ST_AG;
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q != '1) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_AG;
            mode_q  <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            timer_q <= timer_d;
        end
    end

    // Lamps decode straight from the state register, so reset shows them immediately.
    always_comb begin
        L_A = 3'b100;
        L_B = 3'b100;
        case (state_q)
            ST_AG: L_A = 3'b001;
            ST_AY: L_A = 3'b010;
            ST_BG: L_B = 3'b001;
            ST_BY: L_B = 3'b010;
            default: begin
                L_A = 3'b100;
                L_B = 3'b100;
            end
        endcase
    end

    assign MODE  = mode_q;
    assign STATE = state_q;

endmodule

// File: tb/tb_tc_parade_timed.sv
// Directed bench for tc_parade_timed: default instance plus one with MAX_GREEN=20.
// Outputs are sampled on the falling clock edge; inputs change right after sampling.
module tb_tc_parade_timed;

    logic       CLK, RESET, P, R, T_A, T_B;
    logic [2:0] l_a, l_b, m_l_a, m_l_b;
    logic       mode, m_mode;
    logic [1:0] state, m_state;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] AG = 2'b00, AY = 2'b01, BG = 2'b10, BY = 2'b11;

    tc_parade_timed dut (
        .CLK(CLK), .RESET(RESET), .P(P), .R(R), .T_A(T_A), .T_B(T_B),
        .L_A(l_a), .L_B(l_b), .MODE(mode), .STATE(state)
    );

    tc_parade_timed #(.MAX_GREEN(20)) dut_max (
        .CLK(CLK), .RESET(RESET), .P(P), .R(R), .T_A(T_A), .T_B(T_B),
        .L_A(m_l_a), .L_B(m_l_b), .MODE(m_mode), .STATE(m_state)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Expected light state n cycles after reset release with defaults and no traffic.
    function automatic logic [1:0] exp_state(int n);
        int ph;
        ph = n % 30;
        if (ph < 10) return AG;
        if (ph < 15) return AY;
        if (ph < 25) return BG;
        return BY;
    endfunction

    function automatic logic [2:0] exp_la(logic [1:0] s);
        if (s == AG) return 3'b001;
        if (s == AY) return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic [2:0] exp_lb(logic [1:0] s);
        if (s == BG) return 3'b001;
        if (s == BY) return 3'b010;
        return 3'b100;
    endfunction

    // Leaves the bench at the falling edge where reset is released (cycle 0, timer 0).
    task automatic do_reset;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic test_reset;
        P = 0; R = 0; T_A = 0; T_B = 0;
        RESET = 1'b0;
        #1;
        checks++; if (state !== AG) begin failures++; $display("FAIL por_state: got %b want %b", state, AG); end
        checks++; if (l_a !== 3'b001) begin failures++; $display("FAIL por_l_a: got %b want 001", l_a); end
        checks++; if (l_b !== 3'b100) begin failures++; $display("FAIL por_l_b: got %b want 100", l_b); end
        checks++; if (mode !== 1'b0) begin failures++; $display("FAIL por_mode: got %b want 0", mode); end
        @(negedge CLK);
        RESET = 1'b1;
        P = 1'b1;
        @(negedge CLK);
        P = 1'b0;
        repeat (20) @(negedge CLK);
        checks++; if (state !== BG || mode !== 1'b1) begin
            failures++; $display("FAIL parade_bg_before_reset: got state=%b mode=%b want 10/1", state, mode);
        end
        #2 RESET = 1'b0;
        #1;
        checks++; if (state !== AG) begin failures++; $display("FAIL async_reset_state: got %b want 00", state); end
        checks++; if (l_a !== 3'b001 || l_b !== 3'b100) begin
            failures++; $display("FAIL async_reset_lamps: got %b/%b want 001/100", l_a, l_b);
        end
        checks++; if (mode !== 1'b0) begin failures++; $display("FAIL async_reset_mode: got %b want 0", mode); end
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic test_default_cycle;
        P = 0; R = 0; T_A = 0; T_B = 0;
        do_reset();
        for (int i = 0; i < 61; i++) begin
            checks++; if (state !== exp_state(i)) begin
                failures++; $display("FAIL default_state[%0d]: got %b want %b", i, state, exp_state(i));
            end
            checks++; if (l_a !== exp_la(exp_state(i)) || l_b !== exp_lb(exp_state(i))) begin
                failures++; $display("FAIL default_lamps[%0d]: got %b/%b want %b/%b", i, l_a, l_b,
                                     exp_la(exp_state(i)), exp_lb(exp_state(i)));
            end
            checks++; if (!(l_a[2] || l_b[2])) begin
                failures++; $display("FAIL both_non_red[%0d]: got %b/%b want one red", i, l_a, l_b);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_max_green;
        P = 0; R = 0; T_A = 1; T_B = 0;
        do_reset();
        for (int i = 0; i <= 210; i++) begin
            if (i == 19) begin
                checks++; if (m_state !== AG) begin failures++; $display("FAIL max_green_last_ag: got %b want 00", m_state); end
            end
            if (i == 20) begin
                checks++; if (m_state !== AY) begin failures++; $display("FAIL max_green_ay: got %b want 01", m_state); end
            end
            if (i % 50 == 0 || i == 210) begin
                checks++; if (state !== AG) begin failures++; $display("FAIL no_max_hold[%0d]: got %b want 00", i, state); end
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_parade;
        P = 0; R = 0; T_A = 1; T_B = 0;
        do_reset();
        repeat (3) @(negedge CLK);
        P = 1'b1;
        @(negedge CLK);                       // cycle 4
        P = 1'b0;
        checks++; if (mode !== 1'b1) begin failures++; $display("FAIL parade_mode_set: got %b want 1", mode); end
        repeat (5) @(negedge CLK);            // cycle 9
        checks++; if (state !== AG) begin failures++; $display("FAIL parade_min_ag: got %b want 00", state); end
        @(negedge CLK);                       // cycle 10
        checks++; if (state !== AY) begin failures++; $display("FAIL parade_ay: got %b want 01", state); end
        repeat (5) @(negedge CLK);            // cycle 15
        for (int i = 0; i < 100; i++) begin
            checks++; if (state !== BG || mode !== 1'b1) begin
                failures++; $display("FAIL parade_hold[%0d]: got state=%b mode=%b want 10/1", i, state, mode);
            end
            @(negedge CLK);
        end
        R = 1'b1;
        @(negedge CLK);
        R = 1'b0;
        checks++; if (mode !== 1'b0 || state !== BG) begin
            failures++; $display("FAIL return_edge_k: got state=%b mode=%b want 10/0", state, mode);
        end
        @(negedge CLK);
        checks++; if (state !== BY) begin failures++; $display("FAIL return_by: got %b want 11", state); end
    endtask

    task automatic test_p_and_r;
        P = 1; R = 1; T_A = 0; T_B = 0;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            checks++; if (state !== exp_state(i) || mode !== 1'b0) begin
                failures++; $display("FAIL p_and_r[%0d]: got state=%b mode=%b want %b/0", i, state, mode, exp_state(i));
            end
            @(negedge CLK);
        end
        R = 1'b0;
        @(negedge CLK);
        checks++; if (mode !== 1'b1) begin failures++; $display("FAIL p_after_r_drop: got %b want 1", mode); end
        P = 1'b0;
    endtask

    task automatic test_reset_mid_phase;
        P = 0; R = 0; T_A = 0; T_B = 0;
        do_reset();
        repeat (11) @(negedge CLK);
        checks++; if (state !== AY) begin failures++; $display("FAIL mid_reset_pre_ay: got %b want 01", state); end
        #2 RESET = 1'b0;
        #1;
        checks++; if (state !== AG || l_a !== 3'b001 || l_b !== 3'b100 || mode !== 1'b0) begin
            failures++; $display("FAIL mid_reset_outputs: got %b %b %b %b want 00 001 100 0", state, l_a, l_b, mode);
        end
        @(negedge CLK);
        RESET = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++; if (state !== AG) begin failures++; $display("FAIL mid_reset_ag[%0d]: got %b want 00", i, state); end
            @(negedge CLK);
        end
        checks++; if (state !== AY) begin failures++; $display("FAIL mid_reset_ay_after: got %b want 01", state); end
    endtask

    initial begin
        test_reset();
        test_default_cycle();
        test_max_green();
        test_parade();
        test_p_and_r();
        test_reset_mid_phase();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
